mem_arbiter: RTL and testbench

- Arbitrates the instruction-fetch port and the data (load/store) port onto one shared single-port memory bus.
- Prepares the core for replacing the on-chip instruction and data memories with one external memory controller.
- Sits between the pipeline fetch/memory stages and the memory controller.
- Provides request/ack handshakes to the pipeline and a valid/ready + rvalid bus to memory, with starvation protection and a response timeout.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access.
// Data normally wins contested grants; fetch is forced through after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_if_req,
   input  logic [ADDR_WIDTH-1:0]   i_if_addr,
   output logic [DATA_WIDTH-1:0]   o_if_rdata,
   output logic                    o_if_ack,
   input  logic                    i_dm_req,
   input  logic                    i_dm_wr_en,
   input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
   input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_dm_wstrb,
   output logic [DATA_WIDTH-1:0]   o_dm_rdata,
   output logic                    o_dm_ack,
   output logic                    o_mem_valid,
   output logic                    o_mem_wr_en,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
   input  logic                    i_mem_ready,
   input  logic                    i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
   output logic                    o_err_timeout,
   output logic                    o_busy
);

   localparam int   STRB_W   = DATA_WIDTH / 8;
   localparam int   STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int   TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_DM  = 1'b1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      ACK       = 2'd3
   } state_t;

   state_t                  state_r,      state_s;
   logic [STARVE_W-1:0]     starve_cnt_r, starve_cnt_s;
   logic [TMO_W-1:0]        tmo_cnt_r,    tmo_cnt_s;
   logic                    port_r,       port_s;
   logic                    wr_en_r,      wr_en_s;
   logic [ADDR_WIDTH-1:0]   addr_r,       addr_s;
   logic [DATA_WIDTH-1:0]   wdata_r,      wdata_s;
   logic [STRB_W-1:0]       wstrb_r,      wstrb_s;
   logic                    mem_valid_r,  mem_valid_s;
   logic                    if_ack_r,     if_ack_s;
   logic                    dm_ack_r,     dm_ack_s;
   logic [DATA_WIDTH-1:0]   if_rdata_r,   if_rdata_s;
   logic [DATA_WIDTH-1:0]   dm_rdata_r,   dm_rdata_s;
   logic                    err_r,        err_s;
   logic                    busy_r,       busy_s;
   logic                    ack_s;
   logic [DATA_WIDTH-1:0]   ack_rdata_s;

   // Next-state, arbitration and next registered-output computation
   always_comb begin
      state_s      = state_r;
      starve_cnt_s = starve_cnt_r;
      tmo_cnt_s    = tmo_cnt_r;
      port_s       = port_r;
      wr_en_s      = wr_en_r;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      wstrb_s      = wstrb_r;
      mem_valid_s  = 1'b0;
      if_ack_s     = 1'b0;
      dm_ack_s     = 1'b0;
      if_rdata_s   = '0;
      dm_rdata_s   = '0;
      err_s        = 1'b0;
      ack_s        = 1'b0;
      ack_rdata_s  = '0;

      case (state_r)
         IDLE: begin
            if (i_dm_req && !(i_if_req && (starve_cnt_r == STARVE_W'(STARVE_LIMIT)))) begin
               port_s      = PORT_DM;
               wr_en_s     = i_dm_wr_en;
               addr_s      = i_dm_addr;
               wdata_s     = i_dm_wdata;
               wstrb_s     = i_dm_wstrb;
               state_s     = ISSUE;
               mem_valid_s = 1'b1;
               // only a contested data win counts towards fetch starvation
               if (i_if_req && (starve_cnt_r != STARVE_W'(STARVE_LIMIT))) begin
                  starve_cnt_s = starve_cnt_r + STARVE_W'(1);
               end else begin
                  starve_cnt_s = starve_cnt_r;
               end
            end else if (i_if_req) begin
               port_s       = PORT_IF;
               wr_en_s      = 1'b0;
               addr_s       = i_if_addr;
               wdata_s      = '0;
               wstrb_s      = '1;
               state_s      = ISSUE;
               mem_valid_s  = 1'b1;
               starve_cnt_s = '0;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (i_mem_ready) begin
               if (wr_en_r) begin
                  state_s = ACK;
                  ack_s   = 1'b1;
               end else begin
                  state_s   = WAIT_RESP;
                  tmo_cnt_s = '0;
               end
            end else begin
               mem_valid_s = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (i_mem_rvalid) begin
               state_s     = ACK;
               ack_s       = 1'b1;
               ack_rdata_s = i_mem_rdata;
            end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state_s   = ACK;
               ack_s     = 1'b1;
               err_s     = 1'b1;
               tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
            end else begin
               tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
            end
         end
         ACK: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (ack_s) begin
         if (port_r == PORT_DM) begin
            dm_ack_s   = 1'b1;
            dm_rdata_s = ack_rdata_s;
         end else begin
            if_ack_s   = 1'b1;
            if_rdata_s = ack_rdata_s;
         end
      end else begin
         if_ack_s = 1'b0;
         dm_ack_s = 1'b0;
      end

      busy_s = (state_s != IDLE);
   end

   // State, latched command and registered outputs
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r      <= IDLE;
         starve_cnt_r <= '0;
         tmo_cnt_r    <= '0;
         port_r       <= 1'b0;
         wr_en_r      <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= '0;
         wstrb_r      <= '0;
         mem_valid_r  <= 1'b0;
         if_ack_r     <= 1'b0;
         dm_ack_r     <= 1'b0;
         if_rdata_r   <= '0;
         dm_rdata_r   <= '0;
         err_r        <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         starve_cnt_r <= starve_cnt_s;
         tmo_cnt_r    <= tmo_cnt_s;
         port_r       <= port_s;
         wr_en_r      <= wr_en_s;
         addr_r       <= addr_s;
         wdata_r      <= wdata_s;
         wstrb_r      <= wstrb_s;
         mem_valid_r  <= mem_valid_s;
         if_ack_r     <= if_ack_s;
         dm_ack_r     <= dm_ack_s;
         if_rdata_r   <= if_rdata_s;
         dm_rdata_r   <= dm_rdata_s;
         err_r        <= err_s;
         busy_r       <= busy_s;
      end
   end

   assign o_if_rdata    = if_rdata_r;
   assign o_if_ack      = if_ack_r;
   assign o_dm_rdata    = dm_rdata_r;
   assign o_dm_ack      = dm_ack_r;
   assign o_mem_valid   = mem_valid_r;
   assign o_mem_wr_en   = wr_en_r;
   assign o_mem_addr    = addr_r;
   assign o_mem_wdata   = wdata_r;
   assign o_mem_wstrb   = wstrb_r;
   assign o_err_timeout = err_r;
   assign o_busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions, a scoreboard of
// expected acks, and hand-written sequences for starvation, back-to-back and reset.
module tb_mem_arbiter;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;
   localparam int STV = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req = 1'b0;
   logic          dm_wr_en = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [SW-1:0] dm_wstrb = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_valid;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;
   logic          mem_ready = 1'b0;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          err_timeout;
   logic          busy;

   always #5 clk = ~clk;

   mem_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(STV), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
      .i_dm_req(dm_req), .i_dm_wr_en(dm_wr_en), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .i_dm_wstrb(dm_wstrb), .o_dm_rdata(dm_rdata), .o_dm_ack(dm_ack),
      .o_mem_valid(mem_valid), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
      .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
      .o_err_timeout(err_timeout), .o_busy(busy)
   );

   typedef struct {
      logic    port;
      logic    rdata_unused;
      logic [DW-1:0] rdata;
      logic    err;
   } exp_t;

   typedef struct {
      logic          port;      // 1 = data port
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      int            rdy;       // cycles of valid before ready
      int            resp;      // cycles after acceptance before rvalid, -1 = never
      logic [DW-1:0] resp_data;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;   // cycles from request to ack
   } vec_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic          auto_mem = 1'b0;
   logic          pend = 1'b0;
   logic [DW-1:0] pend_data = '0;
   int            valid_cyc[$];
   vec_t          vecs[6];

   function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [10:0] outs();
      return {mem_valid, if_ack, dm_ack, err_timeout, busy, |if_rdata, |dm_rdata,
              |mem_addr, |mem_wdata, |mem_wstrb, mem_wr_en};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // advance one cycle, check any ack against the scoreboard, run the auto memory
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (if_ack || dm_ack) begin
         chk("single_ack", {31'd0, if_ack & dm_ack}, 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_ack", {62'd0, if_ack, dm_ack}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_port", {63'd0, dm_ack}, {63'd0, e.port});
            chk("ack_rdata", e.port ? dm_rdata : if_rdata, e.rdata);
            chk("other_rdata_zero", e.port ? if_rdata : dm_rdata, 64'd0);
            chk("err_timeout", {63'd0, err_timeout}, {63'd0, e.err});
         end
      end else if (err_timeout) begin
         chk("stray_err_timeout", {63'd0, err_timeout}, 64'd0);
      end
      if (auto_mem) begin
         mem_rvalid = pend;
         mem_rdata  = pend ? pend_data : '0;
         pend       = 1'b0;
         mem_ready  = mem_valid;
         if (mem_valid) begin
            valid_cyc.push_back(cyc);
            if (!mem_wr_en) begin
               pend      = 1'b1;
               pend_data = mem_f(mem_addr);
            end
         end
      end
   endtask

   task automatic do_txn(input vec_t v);
      int   t0;
      logic got;
      exp_t e;
      e.port = v.port; e.rdata_unused = 1'b0; e.rdata = v.exp_rdata; e.err = v.exp_err;
      sb.push_back(e);
      if (v.port) begin
         dm_req = 1'b1; dm_wr_en = v.wr; dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.wstrb;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      t0 = cyc;
      for (int k = 0; k <= v.rdy; k++) begin
         step();
         chk("mem_valid_held", {63'd0, mem_valid}, 64'd1);
         chk("mem_cmd", {mem_wr_en, mem_addr, mem_wstrb},
             {v.wr, v.addr, (v.port ? v.wstrb : 4'hF)});
         if (v.wr) chk("mem_wdata", mem_wdata, v.wdata);
         mem_ready = (k == v.rdy);
      end
      step();
      mem_ready = 1'b0;
      chk("valid_drop", {63'd0, mem_valid}, 64'd0);
      if (!v.wr && v.resp >= 0) begin
         repeat (v.resp) step();
         mem_rvalid = 1'b1; mem_rdata = v.resp_data;
         step();
         mem_rvalid = 1'b0; mem_rdata = '0;
      end
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         if (v.port ? dm_ack : if_ack) got = 1'b1;
         else step();
      end
      chk("ack_seen", {63'd0, got}, 64'd1);
      chk("ack_latency", 64'(cyc - t0), 64'(v.exp_lat));
      if_req = 1'b0; dm_req = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   n;
      int   dmk;
      int   ifk;
      exp_t e;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 2, -1, 32'h0, 32'h0, 1'b0, 4};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1, 2, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 6};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'h0, 0, -1, 32'h0, 32'h0, 1'b1, 2 + TMO};
      vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b1000, 0, -1, 32'h0, 32'h0, 1'b0, 2};
      vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, 0, 1, 32'h0000_0001, 32'h0000_0001, 1'b0, 4};

      // reset state
      step(); step();
      chk("reset_outputs", {53'd0, outs()}, 64'd0);
      rst_n = 1'b1;
      step();
      chk("idle_after_reset", {53'd0, outs()}, 64'd0);

      for (int i = 0; i < 6; i++) begin
         do_txn(vecs[i]);
         if (i == 3) begin
            // late response after the timeout must be ignored
            mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
            step();
            mem_rvalid = 1'b0; mem_rdata = '0;
            for (int j = 0; j < 3; j++) begin
               step();
               chk("late_rvalid_ignored", {61'd0, if_ack, dm_ack, busy}, 64'd0);
            end
         end
      end

      // back-to-back fetches with zero-wait memory
      auto_mem = 1'b1;
      valid_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         e.port = 1'b0; e.rdata_unused = 1'b0; e.rdata = mem_f(AW'(4 * k)); e.err = 1'b0;
         sb.push_back(e);
      end
      if_req = 1'b1; if_addr = '0; n = 0;
      for (int w = 0; w < 100 && n < 3; w++) begin
         step();
         if (if_ack) begin
            n++;
            if_addr = if_addr + 32'd4;
            if (n == 3) if_req = 1'b0;
         end
      end
      chk("b2b_acks", 64'(n), 64'd3);
      chk("b2b_valid_count", 64'(valid_cyc.size()), 64'd3);
      if (valid_cyc.size() == 3) begin
         chk("b2b_spacing_0", 64'(valid_cyc[1] - valid_cyc[0]), 64'd4);
         chk("b2b_spacing_1", 64'(valid_cyc[2] - valid_cyc[1]), 64'd4);
      end
      step(); step();

      // both ports requesting continuously: DM x STV then IF, twice
      dmk = 0; ifk = 0;
      for (int g = 0; g < 10; g++) begin
         e.rdata_unused = 1'b0; e.err = 1'b0;
         if ((g % 5) == 4) begin
            e.port = 1'b0; e.rdata = mem_f(32'h200 + AW'(4 * ifk)); ifk++;
         end else begin
            e.port = 1'b1; e.rdata = mem_f(32'h100 + AW'(4 * dmk)); dmk++;
         end
         sb.push_back(e);
      end
      dm_wr_en = 1'b0; dm_wstrb = '0; dm_addr = 32'h100; if_addr = 32'h200;
      if_req = 1'b1; dm_req = 1'b1; n = 0;
      for (int w = 0; w < 300 && n < 10; w++) begin
         step();
         if (dm_ack) dm_addr = dm_addr + 32'd4;
         if (if_ack) if_addr = if_addr + 32'd4;
         if (dm_ack || if_ack) n++;
         if (n == 10) begin
            if_req = 1'b0; dm_req = 1'b0;
         end
      end
      chk("starve_acks", 64'(n), 64'd10);
      step(); step();
      auto_mem = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      chk("sb_drained", 64'(sb.size()), 64'd0);

      // asynchronous reset while waiting for a read response
      if_req = 1'b1; if_addr = 32'h300;
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      step();
      chk("busy_before_reset", {63'd0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", {53'd0, outs()}, 64'd0);
      if_req = 1'b0;
      step();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
      step();
      mem_rvalid = 1'b0; mem_rdata = '0;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("no_ack_after_reset", {61'd0, if_ack, dm_ack, busy}, 64'd0);
      end
      do_txn(vecs[0]);
      chk("sb_final", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
